fifo_write_relay: RTL and testbench
===================================

// Module: fifo_write_relay
// PURPOSE
//  Producer-side register slice that drives the write port of a FWFT FIFO.
//  Presents a FIFO-style write interface upstream (full_n/write_ce/write/din).
//  Drives a FIFO write port downstream (full_n in, write/din out).
//  Registers every handshake in both directions at full throughput, so long
//  producer-to-FIFO paths can be pipelined.
// PARAMETERS
//  DATA_WIDTH   32  width of if_din / fifo_din
//  COUNT_WIDTH  32  width of statistics counters (only with FIFO_WRITE_RELAY_STATS_EN)
// PORTS
//  clk          in   1           clock
//  reset_n      in   1           asynchronous reset, active-low
//  if_full_n    out  1           upstream: relay can accept a word
//  if_write_ce  in   1           upstream write clock-enable
//  if_write     in   1           upstream write request
//  if_din       in   DATA_WIDTH  upstream write data
//  fifo_full_n  in   1           downstream FIFO not full; its write_ce is tied high
//  fifo_write   out  1           downstream write request
//  fifo_din     out  DATA_WIDTH  downstream write data
// BEHAVIOUR
//  Storage
//  - Main register (m_v, m_d) drives fifo_write = m_v and fifo_din = m_d.
//  - Skid register (s_v, s_d) holds one overflow word.
//  - Invariant: s_v implies m_v.
//  Handshakes
//  - accept = if_full_n & if_write_ce & if_write.
//  - drain  = m_v & fifo_full_n.
//  - if_full_n is a register. It is 0 while reset_n is low.
//  - Otherwise if_full_n is updated each edge to ~s_v(next).
//  States (m_v,s_v)
//  - EMPTY (0,0): accept -> ONE.
//  - ONE (1,0):
//    - drain & accept -> ONE (new word loaded, no bubble).
//    - drain only -> EMPTY.
//    - accept without drain -> TWO (word goes to skid).
//  - TWO (1,1):
//    - drain -> ONE (skid moves to main).
//    - else hold. No accept is possible because if_full_n = 0.
//  Latency and throughput
//  - A word accepted at edge N is on fifo_write/fifo_din after edge N.
//  - Sustained throughput is 1 word/cycle. Strict FIFO order; no loss or duplication.
//  Output stability
//  - Once fifo_write=1, fifo_write and fifo_din hold until an edge with fifo_full_n=1.
//  Gating
//  - if_write_ce=0 or if_write=0 -> no accept, regardless of if_din.
//  Reset
//  - Asserting reset_n=0, including mid-operation, immediately clears m_v and s_v.
//  - fifo_write drops to 0 asynchronously; if_full_n goes to 0; fifo_din goes to 0.
//  - All buffered words are discarded.
//  - After release, if_full_n rises at the first clock edge.
// CONFIGURATION
//  FIFO_WRITE_RELAY_STATS_EN defined
//  - Adds outputs stat_words [COUNT_WIDTH] and stat_stalls [COUNT_WIDTH].
//  - stat_words increments on every drain.
//  - stat_stalls increments on every cycle with m_v & ~fifo_full_n.
//  - Both saturate at all-ones and reset to 0.
//  FIFO_WRITE_RELAY_STATS_EN undefined
//  - Stats ports and counters are absent; datapath is identical.
// TESTING
//  1 Reset hold: reset_n=0 with if_write=1, fifo_full_n=1.
//    -> fifo_write=0, if_full_n=0.
//    Release -> if_full_n=1 after first edge.
//  2 Stream: fifo_full_n=1, write 0x01..0x08 back-to-back.
//    -> fifo_write high 8 consecutive cycles, each word one cycle later, in order.
//    -> if_full_n stays 1.
//  3 Backpressure: fifo_full_n=0, write A,B,C.
//    -> A held on fifo_din; B goes to skid; if_full_n=0; C held by producer.
//    fifo_full_n=1 -> A,B,C on consecutive edges.
//  4 ONE state with drain and accept on the same edge.
//    -> stays ONE, no bubble, no reorder.
//  5 Reset mid-op in TWO state.
//    -> fifo_write=0 before next edge.
//    -> after release, no stale word ever appears.
//  6 Stats (macro defined): 10 words with 3 stall cycles.
//    -> stat_words=10, stat_stalls=3.
//    Preload-to-max case -> counters stay all-ones.

Source files
------------

// File: rtl/fifo_write_relay.sv
// fifo_write_relay: registered producer-side slice driving a FWFT FIFO write port.
// Optional statistics counters enabled by defining FIFO_WRITE_RELAY_STATS_EN.
module fifo_write_relay #(
    parameter int DATA_WIDTH = 32
`ifdef FIFO_WRITE_RELAY_STATS_EN
    ,
    parameter int COUNT_WIDTH = 32
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   if_full_n,
    input  logic                   if_write_ce,
    input  logic                   if_write,
    input  logic [DATA_WIDTH-1:0]  if_din,
    input  logic                   fifo_full_n,
    output logic                   fifo_write,
    output logic [DATA_WIDTH-1:0]  fifo_din
`ifdef FIFO_WRITE_RELAY_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] stat_words,
    output logic [COUNT_WIDTH-1:0] stat_stalls
`endif
);
    logic                  m_v_q, m_v_d, s_v_q, s_v_d, if_full_n_q;
    logic [DATA_WIDTH-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
    logic                  accept, drain;

    assign accept = if_full_n_q & if_write_ce & if_write;
    assign drain  = m_v_q & fifo_full_n;

    // Main refills from skid first; the skid only fills while main is stalled.
    always_comb begin
        m_v_d = m_v_q;
        m_d_d = m_d_q;
        s_v_d = s_v_q;
        s_d_d = s_d_q;
        if (!m_v_q || drain) begin
            m_v_d = s_v_q | accept;
            m_d_d = s_v_q ? s_d_q : accept ? if_din : m_d_q;
            s_v_d = 1'b0;
        end else if (accept) begin
            s_v_d = 1'b1;
            s_d_d = if_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_v_q       <= 1'b0;
            s_v_q       <= 1'b0;
            m_d_q       <= '0;
            s_d_q       <= '0;
            if_full_n_q <= 1'b0;
        end else begin
            m_v_q       <= m_v_d;
            s_v_q       <= s_v_d;
            m_d_q       <= m_d_d;
            s_d_q       <= s_d_d;
            if_full_n_q <= ~s_v_d;
        end
    end

    assign if_full_n  = if_full_n_q;
    assign fifo_write = m_v_q;
    assign fifo_din   = m_d_q;

`ifdef FIFO_WRITE_RELAY_STATS_EN
    logic [COUNT_WIDTH-1:0] stat_words_q, stat_stalls_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (drain && !(&stat_words_q))
                stat_words_q <= stat_words_q + 1'b1;
            if (m_v_q && !fifo_full_n && !(&stat_stalls_q))
                stat_stalls_q <= stat_stalls_q + 1'b1;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_stalls = stat_stalls_q;
`else
    // datapath only, no counters
`endif
endmodule

// File: tb/tb_fifo_write_relay.sv
// tb_fifo_write_relay: scoreboard bench for fifo_write_relay.
// Stats checks compile only when FIFO_WRITE_RELAY_STATS_EN is defined.
module tb_fifo_write_relay;
    logic        clk = 1'b0;
    logic        reset_n, if_full_n, if_write_ce, if_write, fifo_full_n, fifo_write;
    logic [31:0] if_din, fifo_din;
    int          checks = 0, errors = 0;
    logic [31:0] q[$];
`ifdef FIFO_WRITE_RELAY_STATS_EN
    logic [3:0]  stat_words, stat_stalls;
`endif

    always #5 clk = ~clk;

    fifo_write_relay #(
        .DATA_WIDTH(32)
`ifdef FIFO_WRITE_RELAY_STATS_EN
        , .COUNT_WIDTH(4)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .if_full_n(if_full_n), .if_write_ce(if_write_ce),
        .if_write(if_write), .if_din(if_din), .fifo_full_n(fifo_full_n),
        .fifo_write(fifo_write), .fifo_din(fifo_din)
`ifdef FIFO_WRITE_RELAY_STATS_EN
        , .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && fifo_write && fifo_full_n) begin
            if (q.size() == 0) check("spurious_word", fifo_din, 32'hdead_beef);
            else check("order", fifo_din, q.pop_front());
        end
        if (reset_n && if_full_n && if_write_ce && if_write) q.push_back(if_din);
    end

    task automatic send(input logic [31:0] d);
        int n = 0;
        if_write = 1'b1;
        if_din   = d;
        @(negedge clk);
        while (!if_full_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if_write = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; if_write_ce = 1'b1; if_write = 1'b1; if_din = 32'h55; fifo_full_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_write", fifo_write, 0);
        check("rst_if_full_n", if_full_n, 0);
        check("rst_fifo_din", fifo_din, 0);
        @(negedge clk);
        if_write = 1'b0;
        reset_n  = 1'b1;
        #1 check("rel_if_full_n_pre", if_full_n, 0);
        @(posedge clk);
        #1 check("rel_if_full_n_post", if_full_n, 1);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if_write = 1'b1;
            if_din   = 32'(i + 1);
            @(negedge clk);
            check("stream_full_n", if_full_n, 1);
            if (i > 0) begin
                check("stream_write", fifo_write, 1);
                check("stream_din", fifo_din, 32'(i));
            end
        end
        @(posedge clk);
        #1 if_write = 1'b0;
        @(negedge clk);
        check("stream_last_write", fifo_write, 1);
        check("stream_last_din", fifo_din, 32'h8);
        @(negedge clk);
        check("stream_idle", fifo_write, 0);

        @(posedge clk);
        #1 fifo_full_n = 1'b0;
        send(32'hA);
        send(32'hB);
        if_write = 1'b1;
        if_din   = 32'hC;
        repeat (3) @(negedge clk);
        check("bp_hold_write", fifo_write, 1);
        check("bp_hold_din", fifo_din, 32'hA);
        check("bp_full_n", if_full_n, 0);
        @(posedge clk);
        #1 fifo_full_n = 1'b1;
        @(negedge clk);
        check("bp_out_a", fifo_din, 32'hA);
        @(negedge clk);
        check("bp_out_b", fifo_din, 32'hB);
        check("bp_reopen", if_full_n, 1);
        @(posedge clk);
        #1 if_write = 1'b0;
        @(negedge clk);
        check("bp_out_c", fifo_din, 32'hC);
        check("bp_out_c_write", fifo_write, 1);
        @(negedge clk);
        check("bp_idle", fifo_write, 0);

        send(32'hD1);
        send(32'hD2);
        @(negedge clk);
        check("one_same_edge_din", fifo_din, 32'hD2);
        check("one_same_edge_full_n", if_full_n, 1);
        @(negedge clk);

        @(posedge clk);
        #1 fifo_full_n = 1'b0;
        send(32'hE);
        send(32'hF);
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        check("midrst_write", fifo_write, 0);
        check("midrst_full_n", if_full_n, 0);
        check("midrst_din", fifo_din, 0);
        @(negedge clk);
        fifo_full_n = 1'b1;
        reset_n     = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_stale", fifo_write, 0);
        send(32'h77);
        @(negedge clk);
        check("post_rst_din", fifo_din, 32'h77);

`ifdef FIFO_WRITE_RELAY_STATS_EN
        @(negedge clk);
        reset_n = 1'b0;
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 fifo_full_n = 1'b0;
        send(32'h100);
        repeat (3) @(posedge clk);
        #1 fifo_full_n = 1'b1;
        for (int i = 1; i < 10; i++) send(32'h100 + 32'(i));
        repeat (3) @(negedge clk);
        check("stat_words", 32'(stat_words), 10);
        check("stat_stalls", 32'(stat_stalls), 3);
        for (int i = 0; i < 10; i++) send(32'h200 + 32'(i));
        @(posedge clk);
        #1 fifo_full_n = 1'b0;
        send(32'h300);
        repeat (20) @(posedge clk);
        #1 fifo_full_n = 1'b1;
        repeat (3) @(negedge clk);
        check("stat_words_sat", 32'(stat_words), 15);
        check("stat_stalls_sat", 32'(stat_stalls), 15);
`endif

        fifo_full_n = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_all", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
